// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: the handshake signals around the memory-port arbiter.
//   Fetch requester : inst_req, inst_addr -> inst_rdata, inst_done, inst_stall
//   Data requester  : data_req, data_wr, data_wstrb, data_addr, data_wdata
//                     -> data_rdata, data_done, data_stall
//   Memory bus      : bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, bus_err
//                     <- bus_addr_ok, bus_data_ok, bus_rdata
// Modport slave is the arbiter's view; master is the requesters' plus the memory's view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              inst_req;
    logic [AW-1:0]     inst_addr;
    logic [DW-1:0]     inst_rdata;
    logic              inst_done;
    logic              inst_stall;

    logic              data_req;
    logic              data_wr;
    logic [DW/8-1:0]   data_wstrb;
    logic [AW-1:0]     data_addr;
    logic [DW-1:0]     data_wdata;
    logic [DW-1:0]     data_rdata;
    logic              data_done;
    logic              data_stall;

    logic              bus_req;
    logic              bus_wr;
    logic [DW/8-1:0]   bus_wstrb;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DW-1:0]     bus_rdata;
    logic              bus_err;

    modport slave (
        input  inst_req, inst_addr,
        output inst_rdata, inst_done, inst_stall,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_rdata, data_done, data_stall,
        output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, bus_err,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_rdata, inst_done, inst_stall,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_rdata, data_done, data_stall,
        input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, bus_err,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like memory port between instruction fetch
// and data load/store, one outstanding access at a time. Data has priority.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   bus_if - mem_port_arbiter_if.slave (requester handshakes + memory bus)
// Optional: define ARB_TIMEOUT_EN to abort an access that spends TIMEOUT_CYCLES
// in ADDR+WAIT; the abort returns rdata=0 with bus_err pulsed alongside done.
module mem_port_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus_if
);
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_RESP} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;

    state_t          state_q;
    owner_t          owner_q;
    logic            bus_req_q;
    logic            bus_wr_q;
    logic [SW-1:0]   bus_wstrb_q;
    logic [AW-1:0]   bus_addr_q;
    logic [DW-1:0]   bus_wdata_q;
    logic [DW-1:0]   inst_rdata_q;
    logic [DW-1:0]   data_rdata_q;
    logic            inst_done_q;
    logic            data_done_q;
    logic            bus_err_q;

    logic            complete;
    logic            abort;
    logic [DW-1:0]   resp_rdata;

    assign complete = (state_q == S_WAIT) && bus_if.bus_data_ok;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = 16;
    logic [CW-1:0] cnt_q;

    // Counter reads 0 in the first ADDR cycle; aborting at TIMEOUT_CYCLES-1
    // means exactly TIMEOUT_CYCLES cycles were spent in ADDR+WAIT.
    assign abort = ((state_q == S_ADDR) || (state_q == S_WAIT)) && !complete &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == S_ADDR) || (state_q == S_WAIT)) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign abort          = 1'b0;
`endif

    // Stores and aborted accesses return zero data.
    assign resp_rdata = (abort || bus_wr_q) ? '0 : bus_if.bus_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_INST;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_wstrb_q  <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            bus_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus_if.data_req) begin
                        owner_q     <= OWN_DATA;
                        bus_wr_q    <= bus_if.data_wr;
                        bus_wstrb_q <= bus_if.data_wr ? bus_if.data_wstrb : '0;
                        bus_addr_q  <= bus_if.data_addr;
                        bus_wdata_q <= bus_if.data_wdata;
                        bus_req_q   <= 1'b1;
                        state_q     <= S_ADDR;
                    end else if (bus_if.inst_req) begin
                        owner_q     <= OWN_INST;
                        bus_wr_q    <= 1'b0;
                        bus_wstrb_q <= '0;
                        bus_addr_q  <= bus_if.inst_addr;
                        bus_req_q   <= 1'b1;
                        state_q     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus_if.bus_addr_ok) begin
                        bus_req_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: ;
                S_RESP: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // Completion and timeout abort share one exit to RESP; placed after
            // the case so an abort in ADDR overrides the ADDR->WAIT step.
            if (complete || abort) begin
                bus_req_q <= 1'b0;
                bus_err_q <= abort;
                state_q   <= S_RESP;
                if (owner_q == OWN_DATA) begin
                    data_done_q  <= 1'b1;
                    data_rdata_q <= resp_rdata;
                end else begin
                    inst_done_q  <= 1'b1;
                    inst_rdata_q <= resp_rdata;
                end
            end
        end
    end

    assign bus_if.bus_req    = bus_req_q;
    assign bus_if.bus_wr     = bus_wr_q;
    assign bus_if.bus_wstrb  = bus_wstrb_q;
    assign bus_if.bus_addr   = bus_addr_q;
    assign bus_if.bus_wdata  = bus_wdata_q;
    assign bus_if.bus_err    = bus_err_q;
    assign bus_if.inst_rdata = inst_rdata_q;
    assign bus_if.data_rdata = data_rdata_q;
    assign bus_if.inst_done  = inst_done_q;
    assign bus_if.data_done  = data_done_q;
    assign bus_if.inst_stall = bus_if.inst_req & ~inst_done_q;
    assign bus_if.data_stall = bus_if.data_req & ~data_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bif ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bif)
    );

    int checks = 0;
    int errors = 0;

    // Requester state
    bit          ir, dr, dwr;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dst;

    // Transaction-level reference: timeline offsets from the grant cycle
    int          cyc = 0;
    bit          busy = 1'b0, own_d, m_err;
    int          g, A, D, done_cyc = -10, bus_last;
    logic [31:0] l_addr, l_wdata, cap;
    logic        l_wr;
    logic [3:0]  l_strb;

    // Knobs
    int          p_inst = 0, p_data = 0, p_noise = 0;
    int          a_lo = 0, a_hi = 0, d_lo = 0, d_hi = 0;
    bit          fix_rd = 1'b0, force_dok = 1'b0, never_dok = 1'b0;
    logic [31:0] fixed_rd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic new_data();
        da  = $urandom;
        dwr = 1'($urandom_range(1));
        dst = 4'($urandom);
        dwd = $urandom;
    endtask

    task automatic reset_mid_cycle();
        rst = 1'b1;
        ir = 1'b0; dr = 1'b0; busy = 1'b0; force_dok = 1'b0;
        bif.inst_req = 1'b0; bif.inst_addr = '0;
        bif.data_req = 1'b0; bif.data_wr = 1'b0; bif.data_wstrb = '0;
        bif.data_addr = '0; bif.data_wdata = '0;
        bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b0; bif.bus_rdata = '0;
        #1;
        chk("rst_bus_req",    32'(bif.bus_req), 0);
        chk("rst_bus_wr",     32'(bif.bus_wr), 0);
        chk("rst_bus_wstrb",  32'(bif.bus_wstrb), 0);
        chk("rst_bus_addr",   bif.bus_addr, 0);
        chk("rst_bus_wdata",  bif.bus_wdata, 0);
        chk("rst_inst_rdata", bif.inst_rdata, 0);
        chk("rst_data_rdata", bif.data_rdata, 0);
        chk("rst_inst_done",  32'(bif.inst_done), 0);
        chk("rst_data_done",  32'(bif.data_done), 0);
        chk("rst_bus_err",    32'(bif.bus_err), 0);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic tick();
        bit          just_done, aok, dok, exp_req, idone, ddone;
        int          k, dk;
        logic [31:0] rd;
        @(posedge clk);
        #1;
        cyc++;
        just_done = busy && (cyc == done_cyc + 1);
        if (just_done) busy = 1'b0;

        if (just_done && !own_d) begin
            ir = pct(p_inst);
            ia = $urandom;
        end else if (!ir && pct(p_inst)) begin
            ir = 1'b1;
            ia = $urandom;
        end
        if (just_done && own_d) begin
            dr = pct(p_data);
            new_data();
        end else if (!dr && pct(p_data)) begin
            dr = 1'b1;
            new_data();
        end

        if (!busy && (dr || ir)) begin
            busy  = 1'b1;
            own_d = dr;
            g     = cyc;
            A     = int'($urandom_range(a_hi, a_lo));
            D     = never_dok ? 100000 : int'($urandom_range(d_hi, d_lo));
            cap   = '0;
            if (own_d) begin
                l_addr = da; l_wr = dwr; l_strb = dwr ? dst : 4'h0; l_wdata = dwd;
            end else begin
                l_addr = ia; l_wr = 1'b0; l_strb = 4'h0; l_wdata = '0;
            end
            if (TO_EN && (2 + A + D > TO)) begin
                m_err    = 1'b1;
                done_cyc = g + TO + 1;
                bus_last = (1 + A < TO) ? 1 + A : TO;
            end else begin
                m_err    = 1'b0;
                done_cyc = g + 3 + A + D;
                bus_last = 1 + A;
            end
        end

        rd  = fix_rd ? fixed_rd : $urandom;
        aok = 1'b0;
        dok = pct(p_noise);
        if (busy && cyc > g) begin
            k   = cyc - g;
            dk  = done_cyc - g;
            aok = (k == 1 + A);
            if (k >= 2 + A && k < dk) dok = (k == 2 + A + D);
            if (k == 2 + A + D && !m_err) cap = l_wr ? 32'h0 : rd;
        end
        dok = dok || force_dok;

        bif.inst_req   = ir;  bif.inst_addr  = ia;
        bif.data_req   = dr;  bif.data_wr    = dwr;  bif.data_wstrb = dst;
        bif.data_addr  = da;  bif.data_wdata = dwd;
        bif.bus_addr_ok = aok; bif.bus_data_ok = dok; bif.bus_rdata = rd;

        @(negedge clk);
        k       = busy ? cyc - g : -1;
        exp_req = busy && k >= 1 && k <= bus_last;
        idone   = busy && !own_d && cyc == done_cyc;
        ddone   = busy && own_d && cyc == done_cyc;
        chk("bus_req", 32'(bif.bus_req), 32'(exp_req));
        if (exp_req) begin
            chk("bus_addr",  bif.bus_addr, l_addr);
            chk("bus_wr",    32'(bif.bus_wr), 32'(l_wr));
            chk("bus_wstrb", 32'(bif.bus_wstrb), 32'(l_strb));
            if (l_wr) chk("bus_wdata", bif.bus_wdata, l_wdata);
        end
        chk("inst_done",  32'(bif.inst_done), 32'(idone));
        chk("data_done",  32'(bif.data_done), 32'(ddone));
        chk("inst_stall", 32'(bif.inst_stall), 32'(ir && !idone));
        chk("data_stall", 32'(bif.data_stall), 32'(dr && !ddone));
        chk("bus_err",    32'(bif.bus_err), 32'((idone || ddone) && m_err));
        if (idone) chk("inst_rdata", bif.inst_rdata, cap);
        if (ddone) chk("data_rdata", bif.data_rdata, cap);
    endtask

    initial begin
        reset_mid_cycle();

        // Fetch only, zero wait states
        a_lo = 0; a_hi = 0; d_lo = 0; d_hi = 0;
        fix_rd = 1'b1; fixed_rd = 32'h24080005;
        ir = 1'b1; ia = 32'hBFC00000;
        repeat (6) tick();
        fix_rd = 1'b0;

        // Simultaneous requests: data load first, then fetch
        reset_mid_cycle();
        dr = 1'b1; da = 32'h80001000; dwr = 1'b0; dst = 4'hF; dwd = $urandom;
        ir = 1'b1; ia = 32'hBFC00010;
        repeat (10) tick();

        // Store with addr_ok after 2 cycles and data_ok after 3
        reset_mid_cycle();
        a_lo = 2; a_hi = 2; d_lo = 3; d_hi = 3;
        dr = 1'b1; dwr = 1'b1; dst = 4'b0011; dwd = 32'h0000BEEF; da = 32'h80002000;
        repeat (10) tick();

        // Back-to-back fetches with fresh addresses
        reset_mid_cycle();
        a_lo = 0; a_hi = 0; d_lo = 0; d_hi = 0; p_inst = 100;
        ir = 1'b1; ia = $urandom;
        repeat (16) tick();
        p_inst = 0;

        // Reset while waiting for data, then a stray data_ok
        reset_mid_cycle();
        d_lo = 5; d_hi = 5;
        dr = 1'b1; dwr = 1'b0; da = $urandom; dst = 4'hF;
        repeat (4) tick();
        reset_mid_cycle();
        force_dok = 1'b1;
        tick();
        force_dok = 1'b0;
        repeat (3) tick();

        // No data_ok ever: timeout abort if enabled, otherwise a persistent stall
        never_dok = 1'b1; d_lo = 0; d_hi = 0;
        dr = 1'b1; dwr = 1'b0; da = $urandom;
        repeat (60) tick();
        never_dok = 1'b0;
        reset_mid_cycle();

        // Randomized traffic with wait states and stray data_ok
        p_inst = 40; p_data = 30; p_noise = 25;
        a_lo = 0; a_hi = 3; d_lo = 0; d_hi = 3;
        repeat (400) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the pipeline's single external memory port between two requesters: instruction fetch (F stage) and data load/store (M stage).
- Grants one requester at a time and runs one SRAM-like addr/data handshake transaction with one outstanding access.
- Drives per-requester stall signals, which the hazard unit ORs into stallF/stallD and the M-stage freeze.
- Data access has priority over fetch because it belongs to the older instruction.

Parameters:
- AW, 32, address width.
- DW, 32, data width. Must be a multiple of 8.
- TIMEOUT_CYCLES, 255, cycles in ADDR+WAIT before abort. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- inst_req  in  1  fetch request; held with inst_addr stable until inst_done.
- inst_addr  in  AW  fetch address (pcF).
- inst_rdata  out  DW  fetched word; valid while inst_done=1.
- inst_done  out  1  one-cycle completion pulse for fetch.
- inst_stall  out  1  inst_req & ~inst_done.
- data_req  in  1  load/store request; held with fields stable until data_done.
- data_wr  in  1  1=store, 0=load.
- data_wstrb  in  DW/8  store byte enables.
- data_addr  in  AW  data address (aluoutM).
- data_wdata  in  DW  store data (writedataM).
- data_rdata  out  DW  load data; valid while data_done=1.
- data_done  out  1  one-cycle completion pulse for data.
- data_stall  out  1  data_req & ~data_done.
- bus_req  out  1  address-phase request.
- bus_wr  out  1  bus write.
- bus_wstrb  out  DW/8  bus byte enables; forced 0 on reads.
- bus_addr  out  AW  bus address.
- bus_wdata  out  DW  bus write data.
- bus_addr_ok  in  1  address accepted this cycle.
- bus_data_ok  in  1  read data / write ack this cycle.
- bus_rdata  in  DW  bus read data.
- bus_err  out  1  timeout abort flag, pulsed with done.

Behaviour:
- FSM states: IDLE, ADDR, WAIT, RESP. owner register holds INST or DATA.
- IDLE:
  - data_req=1: latch data fields into bus regs, owner=DATA, go ADDR.
  - else inst_req=1: latch inst_addr, bus_wr=0, bus_wstrb=0, owner=INST, go ADDR.
  - else stay.
  - Both requests present: data wins; fetch stays stalled.
- ADDR: bus_req=1 with latched fields. On bus_addr_ok go WAIT. bus_data_ok is ignored in ADDR.
- WAIT: bus_req=0. On bus_data_ok, capture bus_rdata (stores capture 0), then go RESP.
- RESP: owner's done=1 and owner's rdata valid for exactly this cycle. Return to IDLE with no grant in RESP.
- A request seen in the IDLE cycle after RESP is a new transaction.
- Minimum latency, with addr_ok and data_ok asserted immediately: request in cycle 0, done in cycle 3.
- Bus outputs come only from registers; no combinational path from requester inputs to bus pins.
- Requester fields changing mid-transaction have no effect, because they are latched at grant.
- inst_rdata/data_rdata hold their last value outside done. Consumers use them only while done=1.
- The non-owner's done is never asserted.
- Reset, including mid-transaction: state=IDLE, owner=INST.
  - All outputs 0: bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, both rdata, both done, bus_err.
  - An in-flight transaction is abandoned; a stray bus_data_ok after reset is ignored in IDLE.
- Stall outputs are combinational from req and done and are 0 whenever req=0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - An 8..16-bit counter clears on entering ADDR and increments each cycle in ADDR or WAIT.
  - When the counter reaches TIMEOUT_CYCLES, go to RESP with rdata=0 and bus_err=1 alongside the owner's done.
  - bus_err is 0 in all other cycles.
  - bus_data_ok in the same cycle as the timeout takes precedence: normal completion, bus_err=0.
- Disabled: no counter, bus_err tied 0, ADDR/WAIT wait indefinitely.

Test Plan:
- Fetch only: inst_req=1 at addr 0xBFC00000, addr_ok and data_ok immediate, bus_rdata=0x24080005 -> bus_req high in cycle 1 with bus_addr=0xBFC00000 and bus_wr=0; inst_done and inst_rdata=0x24080005 in cycle 3 only; inst_stall high in cycles 0-2.
- Simultaneous requests: inst_req and data_req (load at 0x80001000) both in cycle 0 -> data served first (data_done cycle 3); fetch granted in IDLE cycle 4, inst_done cycle 7; inst_stall high throughout cycles 0-6.
- Store with wait states: data_wr=1, wstrb=4'b0011, wdata=0x0000BEEF, addr_ok delayed 2 cycles, data_ok delayed 3 -> bus_req high 3 cycles with wstrb=0011 and wdata=0x0000BEEF; data_done one cycle after data_ok; data_rdata=0.
- Back-to-back fetches: inst_req held high continuously, addr changes after each done -> each transaction uses the post-done address; no grant in a RESP cycle; 4-cycle period.
- Reset in WAIT: assert rst asynchronously, then data_ok after rst release -> all outputs 0 immediately; no done pulse; FSM in IDLE.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, data_ok never asserted -> done and bus_err pulse together 8 cycles after entering ADDR; rdata=0; without macro: stall persists 50+ cycles, bus_err=0.
